btn_cmd_queue: RTL and testbench

- Sits directly downstream of the button debouncers.
- Consumes their single-cycle press pulses (read, write, sector up, sector down) and maintains the current SD sector address.
- Queues read/write commands, each tagged with the address at press time, in a small FIFO.
- Issues queued commands one at a time to the SD controller using a ready/strobe handshake. Reports queue level, dropped presses and handshake timeouts.

---
 rtl/btn_cmd_pkg.sv | 24 ++
 rtl/btn_cmd_queue_if.sv | 35 +++
 rtl/cmd_fifo.sv | 55 +++++
 rtl/btn_cmd_queue.sv | 144 ++++++++++++++
 tb/tb_btn_cmd_queue.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_cmd_pkg.sv
// Shared encodings for the button command queue: op codes, FSM states, entry width.
// Pure declarations; no timing or flow control of its own.
package btn_cmd_pkg;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DONE   = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 32;

    // Queue entry is {op, addr}
    function automatic int entry_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/btn_cmd_queue_if.sv
// Button-pulse inputs, SD controller handshake and status outputs of the command queue.
// Slave side is the queue; master side drives pulses and sd_ready.
interface btn_cmd_queue_if
    import btn_cmd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              pulse_rd;
    logic              pulse_wr;
    logic              pulse_up;
    logic              pulse_dn;
    logic              sd_ready;
    logic              sd_rd;
    logic              sd_wr;
    logic [ADDR_W-1:0] sd_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic [LVL_W-1:0]  q_level;
    logic              busy;
    logic [7:0]        drop_cnt;
    logic              timeout_err;

    modport master (
        output pulse_rd, pulse_wr, pulse_up, pulse_dn, sd_ready,
        input  sd_rd, sd_wr, sd_addr, cur_addr, q_level, busy, drop_cnt, timeout_err
    );

    modport slave (
        input  pulse_rd, pulse_wr, pulse_up, pulse_dn, sd_ready,
        output sd_rd, sd_wr, sd_addr, cur_addr, q_level, busy, drop_cnt, timeout_err
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered count; push visible one cycle later, head read is combinational.
// No backpressure policy: push on full and pop on empty are ignored, the parent decides what to drop.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign head_dat = mem[rd_ptr];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/btn_cmd_queue.sv
// Turns debounced button pulses into queued SD read/write commands; strobe 2 cycles after a press into an idle queue.
// Presses are dropped (and counted) when the queue is full; issue waits on sd_ready with a bounded accept timeout.
module btn_cmd_queue
    import btn_cmd_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ADDR_MAX = 1023,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic           clk,
    input  logic           rst,
    btn_cmd_queue_if.slave bus
);
    localparam int ENTRY_W = entry_w(ADDR_W);
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(ADDR_MAX);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0]  cur_addr_q;
    logic [ADDR_W-1:0]  sd_addr_q;
    op_e                op_q;
    op_e                push_op;
    state_e             state_q;
    state_e             state_d;
    logic [TO_W-1:0]    to_cnt_q;
    logic               to_fire;
    logic               timeout_err_q;
    logic [7:0]         drop_cnt_q;
    logic [1:0]         drop_inc;
    logic [8:0]         drop_sum;
    logic               any_press;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] push_dat;
    logic [ENTRY_W-1:0] head_dat;
    logic [LVL_W-1:0]   level;

    // Sector address; simultaneous up and down cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q <= '0;
        end else if (bus.pulse_up && !bus.pulse_dn) begin
            cur_addr_q <= (cur_addr_q == MAX_A) ? '0 : cur_addr_q + 1'b1;
        end else if (bus.pulse_dn && !bus.pulse_up) begin
            cur_addr_q <= (cur_addr_q == '0) ? MAX_A : cur_addr_q - 1'b1;
        end
    end

    // Read wins a rd/wr collision; fullness uses the pre-pop count so a same-cycle pop never rescues a push
    assign any_press = bus.pulse_rd | bus.pulse_wr;
    assign push      = any_press & ~full;
    assign push_op   = bus.pulse_rd ? OP_RD : OP_WR;
    assign push_dat  = {push_op, cur_addr_q};
    assign drop_inc  = {1'b0, bus.pulse_rd & bus.pulse_wr} + {1'b0, any_press & full};
    assign drop_sum  = {1'b0, drop_cnt_q} + {7'd0, drop_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        to_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && bus.sd_ready) begin
                    state_d = ST_ISSUE;
                    pop     = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (!bus.sd_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    to_fire = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.sd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sd_addr_q     <= '0;
            op_q          <= OP_RD;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                sd_addr_q <= head_dat[ADDR_W-1:0];
                op_q      <= op_e'(head_dat[ADDR_W]);
            end
            to_cnt_q      <= (state_q == ST_WAIT_ACCEPT) ? to_cnt_q + 1'b1 : '0;
            timeout_err_q <= timeout_err_q | to_fire;
        end
    end

    assign bus.sd_rd       = (state_q == ST_ISSUE) && (op_q == OP_RD);
    assign bus.sd_wr       = (state_q == ST_ISSUE) && (op_q == OP_WR);
    assign bus.sd_addr     = sd_addr_q;
    assign bus.cur_addr    = cur_addr_q;
    assign bus.q_level     = level;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_btn_cmd_queue.sv
// Directed plus randomized bench for btn_cmd_queue against a queue/arithmetic reference model.
module tb_btn_cmd_queue;
    import btn_cmd_pkg::*;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 32;
    localparam int ADDR_MAX = 1023;
    localparam int TIMEOUT  = 40;

    typedef struct {
        bit          wr;
        int unsigned addr;
        int          cyc;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btn_cmd_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    btn_cmd_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ADDR_MAX (ADDR_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    cmd_t        exp_q[$];
    cmd_t        obs_q[$];
    int unsigned m_addr = 0;
    int          m_lvl  = 0;
    int          m_drop = 0;
    int          ctl_mode = 0;
    logic        man_ready = 1'b0;
    int          cyc = 0;
    bit          prev_strobe = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: push/drop rules and wrapping address arithmetic
    task automatic press(input bit r, input bit w, input bit u, input bit d);
        cmd_t c;
        bus.pulse_rd = r;
        bus.pulse_wr = w;
        bus.pulse_up = u;
        bus.pulse_dn = d;
        if (r || w) begin
            if (r && w) m_drop++;
            if (m_lvl >= DEPTH) begin
                m_drop++;
            end else begin
                c.wr   = !r;
                c.addr = m_addr;
                c.cyc  = 0;
                exp_q.push_back(c);
                m_lvl++;
            end
        end
        if (u && !d) m_addr = (m_addr == ADDR_MAX) ? 0 : m_addr + 1;
        else if (d && !u) m_addr = (m_addr == 0) ? ADDR_MAX : m_addr - 1;
        cycle();
        bus.pulse_rd = 1'b0;
        bus.pulse_wr = 1'b0;
        bus.pulse_up = 1'b0;
        bus.pulse_dn = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        m_addr = 0;
        m_lvl  = 0;
        m_drop = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk("strobe_wait", 64'(obs_q.size()), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((bus.busy !== 1'b0 || bus.q_level !== '0) && k < budget) begin
            cycle();
            k++;
        end
        chk("idle_wait", 64'(k < budget), 64'd1);
    endtask

    task automatic check_issued(input string tag);
        int n;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_op"},   64'(obs_q[i].wr),   64'(exp_q[i].wr));
            chk({tag, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
        end
        obs_q.delete();
        exp_q.delete();
        m_lvl = 0;
    endtask

    function automatic int sat_drop(input int d);
        return (d > 255) ? 255 : d;
    endfunction

    // Strobe monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("dual_strobe", 64'(bus.sd_rd & bus.sd_wr), 64'd0);
                if (bus.sd_rd || bus.sd_wr) begin
                    cmd_t c;
                    chk("strobe_busy", 64'(bus.busy), 64'd1);
                    chk("strobe_width", 64'(prev_strobe), 64'd0);
                    c.wr   = bus.sd_wr;
                    c.addr = bus.sd_addr;
                    c.cyc  = cyc;
                    obs_q.push_back(c);
                end
                prev_strobe = bus.sd_rd || bus.sd_wr;
            end else begin
                prev_strobe = 1'b0;
            end
        end
    end

    // SD controller model: 0 = manual level, 1 = normal handshake, 2 = never accepts
    initial begin
        bus.sd_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ctl_mode)
                0: bus.sd_ready = man_ready;
                2: bus.sd_ready = 1'b1;
                default: begin
                    bus.sd_ready = 1'b1;
                    if (bus.sd_rd || bus.sd_wr) begin
                        repeat (2) @(posedge clk);
                        #1 bus.sd_ready = 1'b0;
                        repeat (10) @(posedge clk);
                        #1 bus.sd_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin
        int bc;
        int gap;
        bus.pulse_rd = 1'b0;
        bus.pulse_wr = 1'b0;
        bus.pulse_up = 1'b0;
        bus.pulse_dn = 1'b0;
        ctl_mode = 1;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_cur_addr", 64'(bus.cur_addr), 64'd0);
        chk("rst_q_level", 64'(bus.q_level), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_drop", 64'(bus.drop_cnt), 64'd0);
        chk("rst_err", 64'(bus.timeout_err), 64'd0);
        chk("rst_strobes", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
        chk("rst_sd_addr", 64'(bus.sd_addr), 64'd0);
        rst = 1'b0;
        cycle();

        // Basic read with full handshake and latency
        repeat (3) press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        chk("t1_cur_addr", 64'(bus.cur_addr), 64'(m_addr));
        chk("t1_no_early_strobe", 64'(bus.sd_rd), 64'd0);
        chk("t1_level_n1", 64'(bus.q_level), 64'd1);
        cycle();
        chk("t1_sd_rd", 64'(bus.sd_rd), 64'd1);
        chk("t1_sd_wr", 64'(bus.sd_wr), 64'd0);
        chk("t1_sd_addr", 64'(bus.sd_addr), 64'd3);
        bc = 0;
        while (bus.busy === 1'b1 && bc < 50) begin
            bc++;
            cycle();
        end
        chk("t1_busy_len", 64'(bc), 64'd13);
        chk("t1_idle", 64'(bus.busy), 64'd0);
        chk("t1_sd_addr_held", 64'(bus.sd_addr), 64'd3);
        check_issued("t1");

        // Address wrap
        do_reset();
        press(0, 0, 0, 1);
        chk("t2_wrap_dn", 64'(bus.cur_addr), 64'(m_addr));
        press(0, 0, 1, 0);
        chk("t2_wrap_up", 64'(bus.cur_addr), 64'(m_addr));
        press(0, 0, 1, 1);
        chk("t2_both_zero", 64'(bus.cur_addr), 64'(m_addr));
        press(0, 0, 1, 0);
        press(0, 0, 1, 1);
        chk("t2_both_one", 64'(bus.cur_addr), 64'd1);

        // Fill past full with alternating ops, then drain
        do_reset();
        ctl_mode  = 0;
        man_ready = 1'b0;
        cycle();
        for (int i = 0; i < 6; i++) press(i % 2 == 0, i % 2 == 1, 1, 0);
        chk("t3_level", 64'(bus.q_level), 64'd4);
        chk("t3_drop", 64'(bus.drop_cnt), 64'(m_drop));
        chk("t3_drop_two", 64'(bus.drop_cnt), 64'd2);
        chk("t3_busy", 64'(bus.busy), 64'd0);
        ctl_mode = 1;
        wait_strobes(4, 300);
        wait_idle(100);
        check_issued("t3");

        // Read/write collision
        press(1, 1, 0, 0);
        wait_strobes(1, 20);
        wait_idle(50);
        check_issued("t4");
        chk("t4_drop", 64'(bus.drop_cnt), 64'(sat_drop(m_drop)));

        // Randomized rounds
        for (int r = 0; r < 5; r++) begin
            int n;
            ctl_mode  = 0;
            man_ready = 1'b0;
            cycle();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                int k;
                int kind;
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) begin
                    int sel;
                    sel = $urandom_range(0, 2);
                    press(0, 0, sel != 1, sel != 0);
                end
                kind = $urandom_range(0, 4);
                press(kind < 2 || kind == 4, kind >= 2, 1'($urandom_range(0, 1)), 1'b0);
            end
            chk("rnd_level", 64'(bus.q_level), 64'(m_lvl));
            chk("rnd_drop", 64'(bus.drop_cnt), 64'(sat_drop(m_drop)));
            chk("rnd_cur_addr", 64'(bus.cur_addr), 64'(m_addr));
            ctl_mode = 1;
            wait_strobes(exp_q.size(), 400);
            wait_idle(100);
            check_issued("rnd");
        end

        // Accept timeout, next command still issued
        ctl_mode  = 0;
        man_ready = 1'b0;
        cycle();
        press(1, 0, 1, 0);
        press(0, 1, 0, 0);
        ctl_mode = 2;
        wait_strobes(1, 20);
        repeat (TIMEOUT / 2) cycle();
        chk("t5_err_early", 64'(bus.timeout_err), 64'd0);
        chk("t5_busy_wait", 64'(bus.busy), 64'd1);
        wait_strobes(2, TIMEOUT * 3);
        chk("t5_err_set", 64'(bus.timeout_err), 64'd1);
        gap = (obs_q.size() >= 2) ? obs_q[1].cyc - obs_q[0].cyc : -1;
        chk("t5_gap", 64'(gap), 64'(TIMEOUT + 2));
        repeat (TIMEOUT + 5) cycle();
        chk("t5_idle", 64'(bus.busy), 64'd0);
        chk("t5_err_sticky", 64'(bus.timeout_err), 64'd1);
        ctl_mode = 1;
        check_issued("t5");

        // Reset during WAIT_DONE with entries pending
        ctl_mode  = 0;
        man_ready = 1'b0;
        cycle();
        repeat (3) press(1, 0, 1, 0);
        ctl_mode = 1;
        wait_strobes(1, 20);
        repeat (4) cycle();
        chk("t6_busy_pre", 64'(bus.busy), 64'd1);
        chk("t6_level_pre", 64'(bus.q_level), 64'd2);
        do_reset();
        chk("t6_level", 64'(bus.q_level), 64'd0);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_cur_addr", 64'(bus.cur_addr), 64'd0);
        chk("t6_err_clr", 64'(bus.timeout_err), 64'd0);
        chk("t6_drop_clr", 64'(bus.drop_cnt), 64'd0);
        chk("t6_strobes", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
        repeat (30) cycle();
        chk("t6_no_strobe", 64'(obs_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
